alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Pipeline register stage directly upstream of the combinational ALU.
- Captures a decoded instruction, resolves operand forwarding from the ALU output and from writeback, and muxes in PC/immediate/zero.
- Presents registered src1/src2/alu_op/rd to the ALU under a valid/ready handshake. One entry, no skid; stall propagates combinationally upstream.

Parameters:
- XLEN, 32, datapath width (ALU is fixed at 32).
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- flush  in  1  kill the held entry and any capture this cycle
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  stage can accept this cycle
- in_rs1_addr  in  REG_AW  source 1 register index
- in_rs2_addr  in  REG_AW  source 2 register index
- in_rs1_data  in  XLEN  register-file read of rs1, same cycle
- in_rs2_data  in  XLEN  register-file read of rs2, same cycle
- in_pc  in  XLEN  instruction PC
- in_imm  in  XLEN  sign-extended immediate
- in_a_sel  in  2  src1 select: 00 rs1, 01 pc, 10 zero, 11 zero
- in_b_sel  in  1  src2 select: 0 rs2, 1 imm
- in_alu_op  in  4  ALU opcode, passed through unchanged
- in_rd  in  REG_AW  destination index
- alu_result  in  XLEN  combinational ALU result for the current output entry
- wb_valid  in  1  writeback write this cycle
- wb_rd  in  REG_AW  writeback destination
- wb_data  in  XLEN  writeback data
- out_valid  out  1  entry valid to ALU
- out_ready  in  1  downstream accepts
- out_src1  out  XLEN  ALU operand 1
- out_src2  out  XLEN  ALU operand 2
- out_alu_op  out  4  ALU opcode
- out_rd  out  REG_AW  destination index

Behaviour:
- Reset (async, rstn low): out_valid=0, out_src1=0, out_src2=0, out_alu_op=0, out_rd=0; perf counters=0.
- Handshake and timing:
  - fire_out = out_valid & out_ready.
  - in_ready = ~out_valid | out_ready (combinational).
  - capture = in_valid & in_ready & ~flush.
  - Latency: 1 cycle, capture edge to out_valid.
- Next-state update:
  - If flush: out_valid<=0.
  - Else if capture: load all out_* fields, out_valid<=1.
  - Else if fire_out: out_valid<=0.
  - Else: hold all fields unchanged.
- Operand resolution at capture, evaluated per source s in {rs1, rs2}:
  - Priority 1: s_addr==out_rd, out_rd!=0, fire_out -> alu_result.
  - Priority 2: else wb_valid, wb_rd==s_addr, wb_rd!=0 -> wb_data.
  - Otherwise: in_s_data.
  - x0 never forwards; address 0 always yields in_s_data (0 from the register file).
- Operand mux:
  - src1 = a_sel 00: resolved rs1; 01: in_pc; 1x: 0.
  - src2 = b_sel 0: resolved rs2; 1: in_imm.
  - Forwarding is computed regardless of select; only the mux output is stored.
- Boundary cases:
  - Full + out_ready=0: in_ready=0, entry held bit-exact; wb activity does not modify a held entry.
  - Back-to-back dependent instructions: ALU forward path used; no bubble inserted.
  - Capture and fire in the same cycle: new entry replaces old; out_valid stays 1.
  - Flush with in_valid=1: no capture, out_valid=0 next cycle.
  - Reset mid-hold: entry discarded immediately.
- No arithmetic is performed here. alu_op is not decoded.

Optional Feature:
- Macro ALU_ISSUE_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_issued (32 b): increments on each fire_out.
  - perf_stall (32 b): increments each cycle out_valid & ~out_ready.
  - Both counters wrap at 2^32, reset to 0, and are unaffected by flush.
- When undefined, the ports and counters are absent and the block is otherwise identical.

Test Plan:
- Simple issue: in_a_sel=00, b_sel=1, rs1_data=5, imm=7, op=0000, out_ready=1 -> next cycle out_valid=1, src1=5, src2=7, alu_op=0000.
- ALU forward: instr A rd=3 firing with alu_result=0x64, instr B rs1=3 captured same cycle (rs1_data=0) -> B src1=0x64, no bubble.
- Priority and x0: alu_result=1 (out_rd=4) and wb_rd=4, wb_data=2, B rs2=4 -> src2=1. rd=0 with alu_result=9 and B rs1=0 -> src1=0.
- Backpressure: out_ready=0 for 3 cycles -> in_ready=0, outputs constant; wb write to the held entry's source changes nothing. With ALU_ISSUE_PERF_CNT_EN, perf_stall=3.
- Flush: full entry plus in_valid=1 plus flush -> out_valid=0 next cycle; the following cycle captures normally.
- Async reset: assert rstn=0 mid-hold with no clock edge -> out_valid=0 and all outputs 0 immediately.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ALU issue register with operand forwarding; ALU_ISSUE_PERF_CNT_EN adds perf_issued/perf_stall counters
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [1:0]        in_a_sel,
  input  logic              in_b_sel,
  input  logic [3:0]        in_alu_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_src1,
  output logic [XLEN-1:0]   out_src2,
  output logic [3:0]        out_alu_op,
  output logic [REG_AW-1:0] out_rd
`ifdef ALU_ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_stall
`endif
);
  logic fire_out, capture, alu_fwd_ok, wb_fwd_ok;
  logic [XLEN-1:0] rs1_res, rs2_res, src1_nxt, src2_nxt;
  assign fire_out = out_valid & out_ready;
  assign in_ready = ~out_valid | out_ready;
  assign capture = in_valid & in_ready & ~flush;
  // only a firing entry's result is valid on alu_result; x0 never forwards
  assign alu_fwd_ok = fire_out & (out_rd != '0);
  assign wb_fwd_ok = wb_valid & (wb_rd != '0);
  assign rs1_res = (alu_fwd_ok && in_rs1_addr == out_rd) ? alu_result :
                   (wb_fwd_ok && in_rs1_addr == wb_rd) ? wb_data : in_rs1_data;
  assign rs2_res = (alu_fwd_ok && in_rs2_addr == out_rd) ? alu_result :
                   (wb_fwd_ok && in_rs2_addr == wb_rd) ? wb_data : in_rs2_data;
  assign src1_nxt = in_a_sel[1] ? '0 : in_a_sel[0] ? in_pc : rs1_res;
  assign src2_nxt = in_b_sel ? in_imm : rs2_res;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_src1 <= '0;
      out_src2 <= '0;
      out_alu_op <= '0;
      out_rd <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_src1 <= src1_nxt;
      out_src2 <= src2_nxt;
      out_alu_op <= in_alu_op;
      out_rd <= in_rd;
    end else if (fire_out) begin
      out_valid <= 1'b0;
    end
  end
`ifdef ALU_ISSUE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_issued <= '0;
      perf_stall <= '0;
    end else begin
      perf_issued <= perf_issued + {31'd0, fire_out};
      perf_stall <= perf_stall + {31'd0, out_valid & ~out_ready};
    end
  end
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: table-driven directed checks of alu_issue_stage plus reset/perf sequences
module tb_alu_issue_stage;
  logic clk = 1'b0, rstn, flush, in_valid, in_ready, in_b_sel, wb_valid, out_valid, out_ready;
  logic [4:0] in_rs1_addr, in_rs2_addr, in_rd, wb_rd, out_rd;
  logic [31:0] in_rs1_data, in_rs2_data, in_pc, in_imm, alu_result, wb_data, out_src1, out_src2;
  logic [1:0] in_a_sel;
  logic [3:0] in_alu_op, out_alu_op;
`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [31:0] perf_issued, perf_stall;
`endif
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  alu_issue_stage dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .in_pc(in_pc), .in_imm(in_imm), .in_a_sel(in_a_sel),
    .in_b_sel(in_b_sel), .in_alu_op(in_alu_op), .in_rd(in_rd), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_src1(out_src1), .out_src2(out_src2),
    .out_alu_op(out_alu_op), .out_rd(out_rd)
`ifdef ALU_ISSUE_PERF_CNT_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );
  typedef struct {
    logic [31:0] flush, iv, rs1a, rs2a, rs1d, rs2d, pc, imm, asel, bsel, op, rd, alu, wbv, wbrd, wbd, ordy;
    logic [31:0] e_ir, e_ov, e_s1, e_s2, e_op, e_rd;
  } vec_t;
  vec_t tbl [15];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t t);
    flush = t.flush[0]; in_valid = t.iv[0]; in_rs1_addr = t.rs1a[4:0]; in_rs2_addr = t.rs2a[4:0];
    in_rs1_data = t.rs1d; in_rs2_data = t.rs2d; in_pc = t.pc; in_imm = t.imm;
    in_a_sel = t.asel[1:0]; in_b_sel = t.bsel[0]; in_alu_op = t.op[3:0]; in_rd = t.rd[4:0];
    alu_result = t.alu; wb_valid = t.wbv[0]; wb_rd = t.wbrd[4:0]; wb_data = t.wbd; out_ready = t.ordy[0];
  endtask
  task automatic chk_out(input string tag, input logic ov, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [3:0] op, input logic [4:0] rd);
    chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, " out_src1"}, out_src1, s1);
    chk({tag, " out_src2"}, out_src2, s2);
    chk({tag, " out_alu_op"}, {28'd0, out_alu_op}, {28'd0, op});
    chk({tag, " out_rd"}, {27'd0, out_rd}, {27'd0, rd});
  endtask
  initial begin
    // flush iv rs1a rs2a rs1d rs2d pc imm asel bsel op rd alu wbv wbrd wbd ordy | ir ov s1 s2 op rd
    tbl[0]  = '{0,1,1,0,5,0,0,7,0,1,0,3,0,0,0,0,1, 1,1,5,7,0,3};
    tbl[1]  = '{0,1,3,0,0,0,0,0,0,0,1,4,'h64,0,0,0,1, 1,1,'h64,0,1,4};
    tbl[2]  = '{0,1,5,4,'h11,0,0,0,0,0,2,0,1,1,4,2,1, 1,1,'h11,1,2,0};
    tbl[3]  = '{0,1,0,0,0,0,0,'h20,0,1,3,5,9,1,0,'hdead,1, 1,1,0,'h20,3,5};
    tbl[4]  = '{0,1,0,0,0,0,'h1000,'hfffffffc,1,1,4,6,0,0,0,0,1, 1,1,'h1000,'hfffffffc,4,6};
    tbl[5]  = '{0,1,6,6,'h12,'h13,0,0,2,0,5,7,'h55,0,0,0,1, 1,1,0,'h55,5,7};
    tbl[6]  = '{0,1,1,2,'h12,1,0,0,3,0,6,8,'h66,1,2,'habcd,1, 1,1,0,'habcd,6,8};
    tbl[7]  = '{0,1,8,0,'h99,0,0,0,0,0,'hf,'h1f,0,0,0,0,0, 0,1,0,'habcd,6,8};
    tbl[8]  = '{0,0,0,0,0,0,0,0,0,0,0,0,0,1,2,'h1234,0, 0,1,0,'habcd,6,8};
    tbl[9]  = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,1,0,'habcd,6,8};
    tbl[10] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1, 1,0,0,'habcd,6,8};
    tbl[11] = '{0,1,1,0,'h77,0,0,3,0,1,7,9,0,0,0,0,0, 1,1,'h77,3,7,9};
    tbl[12] = '{1,1,1,0,'hee,0,0,4,0,1,8,10,0,0,0,0,0, 0,0,'h77,3,7,9};
    tbl[13] = '{0,1,2,0,'h42,0,0,8,0,1,9,11,0,0,0,0,0, 1,1,'h42,8,9,11};
    tbl[14] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,1,'h42,8,9,11};
    rstn = 1'b0;
    drive(tbl[9]);
    repeat (2) @(posedge clk);
    #1 chk_out("reset", 1'b0, 0, 0, 4'd0, 5'd0);
    @(negedge clk) rstn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk) drive(tbl[i]);
      #1 chk($sformatf("row%0d in_ready", i), {31'd0, in_ready}, tbl[i].e_ir);
      @(posedge clk);
      #1 chk_out($sformatf("row%0d", i), tbl[i].e_ov[0], tbl[i].e_s1, tbl[i].e_s2, tbl[i].e_op[3:0], tbl[i].e_rd[4:0]);
    end
`ifdef ALU_ISSUE_PERF_CNT_EN
    chk("perf_issued", perf_issued, 7);
    chk("perf_stall", perf_stall, 5);
`endif
    // async reset while an entry is held: outputs clear without a clock edge
    @(negedge clk) rstn = 1'b0;
    #1 chk_out("async_reset", 1'b0, 0, 0, 4'd0, 5'd0);
`ifdef ALU_ISSUE_PERF_CNT_EN
    chk("perf_issued reset", perf_issued, 0);
    chk("perf_stall reset", perf_stall, 0);
`endif
    @(negedge clk) rstn = 1'b1;
    drive(tbl[0]);
    @(posedge clk);
    #1 chk_out("post_reset", 1'b1, 5, 7, 4'd0, 5'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
